// File: rtl/mul_rs_pkg.sv
//==============================================================================
// mul_rs_pkg: shared widths, entry types and CDB snoop helper for the
// multiplier reservation station.                               Rev 1.0
//==============================================================================
`default_nettype none

package mul_rs_pkg;

   localparam int ROB_IX_W = 3;
   localparam int DATA_W   = 32;

   typedef struct packed {
      logic                rdy;
      logic [DATA_W-1:0]   val;
      logic [ROB_IX_W-1:0] tag;
   } operand_t;

   typedef struct packed {
      logic                busy;
      logic [ROB_IX_W-1:0] rob_ix;
      operand_t            src1;
      operand_t            src2;
   } rs_entry_t;

   // Only a waiting operand may capture; a stale tag on a ready operand is ignored.
   function automatic operand_t snoop_cdb(input operand_t            op,
                                          input logic                cdb_valid,
                                          input logic [ROB_IX_W-1:0] cdb_tag,
                                          input logic [DATA_W-1:0]   cdb_data);
      operand_t res;
      res = op;
      if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
         res.rdy = 1'b1;
         res.val = cdb_data;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_reservation_station_if.sv
//==============================================================================
// mul_reservation_station_if: dispatch, CDB and multiplier issue bundle.
//                                                                Rev 1.0
//==============================================================================
`default_nettype none

interface mul_reservation_station_if #(
   parameter int DEPTH = 4
);
   import mul_rs_pkg::*;

   logic                       flush_in;
   logic                       dispatch_valid_in;
   logic                       dispatch_ready_out;
   logic [ROB_IX_W-1:0]        rob_ix_in;
   logic                       src1_rdy_in;
   logic [DATA_W-1:0]          src1_val_in;
   logic [ROB_IX_W-1:0]        src1_tag_in;
   logic                       src2_rdy_in;
   logic [DATA_W-1:0]          src2_val_in;
   logic [ROB_IX_W-1:0]        src2_tag_in;
   logic                       cdb_valid_in;
   logic [ROB_IX_W-1:0]        cdb_rob_ix_in;
   logic [DATA_W-1:0]          cdb_data_in;
   logic                       mul_ready_in;
   logic                       mul_valid_out;
   logic [DATA_W-1:0]          mul_rval1_out;
   logic [DATA_W-1:0]          mul_rval2_out;
   logic [ROB_IX_W-1:0]        mul_rob_ix_out;
   logic [$clog2(DEPTH):0]     occupancy_out;

   modport slave (
      input  flush_in, dispatch_valid_in, rob_ix_in,
      input  src1_rdy_in, src1_val_in, src1_tag_in,
      input  src2_rdy_in, src2_val_in, src2_tag_in,
      input  cdb_valid_in, cdb_rob_ix_in, cdb_data_in, mul_ready_in,
      output dispatch_ready_out, mul_valid_out, mul_rval1_out, mul_rval2_out,
      output mul_rob_ix_out, occupancy_out
   );

   modport master (
      output flush_in, dispatch_valid_in, rob_ix_in,
      output src1_rdy_in, src1_val_in, src1_tag_in,
      output src2_rdy_in, src2_val_in, src2_tag_in,
      output cdb_valid_in, cdb_rob_ix_in, cdb_data_in, mul_ready_in,
      input  dispatch_ready_out, mul_valid_out, mul_rval1_out, mul_rval2_out,
      input  mul_rob_ix_out, occupancy_out
   );

endinterface

`default_nettype wire

// File: rtl/age_matrix_picker.sv
//==============================================================================
// age_matrix_picker: dispatch-order age matrix returning the oldest eligible
// entry as a one-hot grant.                                      Rev 1.0
//==============================================================================
`default_nettype none

module age_matrix_picker #(
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [DEPTH-1:0] alloc_in,
   input  logic [DEPTH-1:0] eligible_in,
   output logic [DEPTH-1:0] grant_out
);

   // r_older[i][j] = 1 : entry i was allocated before entry j
   logic [DEPTH-1:0] r_older [DEPTH];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (alloc_in[k]) begin
               for (int j = 0; j < DEPTH; j++) begin
                  r_older[k][j] <= 1'b0;
                  if (j != k) r_older[j][k] <= 1'b1;
               end
            end
         end
      end
   end

   // Stale rows of freed entries never matter: they are masked by eligible_in.
   always_comb begin
      grant_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant_out[i] = eligible_in[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (eligible_in[j] && r_older[j][i]) grant_out[i] = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_reservation_station.sv
//==============================================================================
// mul_reservation_station: buffers multiply ops, wakes them from the CDB and
// issues the oldest ready one to the multiplier.                 Rev 1.0
//==============================================================================
`default_nettype none

module mul_reservation_station
   import mul_rs_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   mul_reservation_station_if.slave   bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   rs_entry_t        r_entries [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic [DEPTH-1:0] w_eligible;
   logic [DEPTH-1:0] w_grant;
   logic [DEPTH-1:0] w_free_sel;
   logic [DEPTH-1:0] w_alloc;
   logic             w_ready;
   logic             w_accept;
   logic             w_issue;
   operand_t         w_new_src1;
   operand_t         w_new_src2;

   assign w_ready  = (r_count < CNT_W'(DEPTH));
   assign w_accept = bus.dispatch_valid_in & w_ready & ~bus.flush_in;
   assign w_issue  = (|w_eligible) & bus.mul_ready_in & ~bus.flush_in;
   assign w_alloc  = w_accept ? w_free_sel : '0;

   assign bus.dispatch_ready_out = w_ready;
   assign bus.mul_valid_out      = w_issue;
   assign bus.occupancy_out      = r_count;

   // Incoming operands see the same-cycle CDB broadcast (bypass).
   assign w_new_src1 = snoop_cdb(operand_t'{rdy: bus.src1_rdy_in, val: bus.src1_val_in,
                                            tag: bus.src1_tag_in},
                                 bus.cdb_valid_in, bus.cdb_rob_ix_in, bus.cdb_data_in);
   assign w_new_src2 = snoop_cdb(operand_t'{rdy: bus.src2_rdy_in, val: bus.src2_val_in,
                                            tag: bus.src2_tag_in},
                                 bus.cdb_valid_in, bus.cdb_rob_ix_in, bus.cdb_data_in);

   always_comb begin
      w_eligible = '0;
      w_free_sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_eligible[i] = r_entries[i].busy & r_entries[i].src1.rdy & r_entries[i].src2.rdy;
         if (!r_entries[i].busy) begin
            w_free_sel    = '0;
            w_free_sel[i] = 1'b1;
         end
      end
   end

   age_matrix_picker #(
      .DEPTH (DEPTH)
   ) u_picker (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .alloc_in    (w_alloc),
      .eligible_in (w_eligible),
      .grant_out   (w_grant)
   );

   always_comb begin
      bus.mul_rval1_out  = '0;
      bus.mul_rval2_out  = '0;
      bus.mul_rob_ix_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_grant[i]) begin
            bus.mul_rval1_out  = bus.mul_rval1_out  | r_entries[i].src1.val;
            bus.mul_rval2_out  = bus.mul_rval2_out  | r_entries[i].src2.val;
            bus.mul_rob_ix_out = bus.mul_rob_ix_out | r_entries[i].rob_ix;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
         r_count <= '0;
      end else if (bus.flush_in) begin
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && w_grant[i]) begin
               r_entries[i].busy <= 1'b0;
            end else if (w_alloc[i]) begin
               r_entries[i] <= rs_entry_t'{busy: 1'b1, rob_ix: bus.rob_ix_in,
                                           src1: w_new_src1, src2: w_new_src2};
            end else if (r_entries[i].busy) begin
               r_entries[i].src1 <= snoop_cdb(r_entries[i].src1, bus.cdb_valid_in,
                                              bus.cdb_rob_ix_in, bus.cdb_data_in);
               r_entries[i].src2 <= snoop_cdb(r_entries[i].src2, bus.cdb_valid_in,
                                              bus.cdb_rob_ix_in, bus.cdb_data_in);
            end
         end
         r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
      end
   end

endmodule

`default_nettype wire
